// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared RV32I control definitions for the sequencer and ALU controller
package riscv_ctrl_pkg;

    // Major opcodes handled by the multi-cycle core
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Instruction class latched at DECODE; CLS_NONE marks an unsupported opcode
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4
    } instr_class_e;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_e;

    // ALU controller operation classes
    localparam logic [1:0] ALU_OP_IALU  = 2'b00;
    localparam logic [1:0] ALU_OP_ADD   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    // Trap cause codes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Map a major opcode onto its instruction class
    function automatic instr_class_e decode_class(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OPC_R_TYPE: cls = CLS_R;
            OPC_I_ALU:  cls = CLS_I;
            OPC_LOAD:   cls = CLS_LW;
            OPC_STORE:  cls = CLS_SW;
            default:    cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // ALU operation class requested for an instruction class
    function automatic logic [1:0] alu_op_of(input instr_class_e cls);
        logic [1:0] op;
        case (cls)
            CLS_R:   op = ALU_OP_RTYPE;
            CLS_LW:  op = ALU_OP_ADD;
            CLS_SW:  op = ALU_OP_ADD;
            default: op = ALU_OP_IALU;
        endcase
        return op;
    endfunction

    // ALU B-operand select: everything except R-type uses the immediate
    function automatic logic alu_src_of(input instr_class_e cls);
        return (cls == CLS_I) || (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait-cycle counter for the shared memory handshake
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int             TW    = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]  LIMIT = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0]  ONE   = TW'(1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Clear wins over count; the counter parks at LIMIT so it never wraps back to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencer with shared-memory handshake and trap
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [6:0]           Opcode,
    input  logic                 Mem_Ready,
    output logic                 Mem_Req,
    output logic                 Mem_Sel,
    output logic                 Mem_Read,
    output logic                 Mem_Write,
    output logic                 IR_Write,
    output logic                 PC_Write,
    output logic                 Reg_Write,
    output logic                 Mem_to_Reg,
    output logic                 ALU_Src,
    output logic [1:0]           ALU_Op,
    output logic                 Busy,
    output logic                 Trap,
    output logic [1:0]           Trap_Cause,
    output logic [CNT_WIDTH-1:0] Instr_Count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    ctrl_state_e            state_q;
    ctrl_state_e            state_d;
    instr_class_e           class_q;
    instr_class_e           class_d;
    logic [1:0]             cause_q;
    logic [1:0]             cause_d;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   count_d;

    logic                   in_wait_state;
    logic                   wait_clear;
    logic                   wait_count;
    logic                   wait_expired;
    logic                   retire;

    assign in_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Any state change restarts the wait count, so each FETCH/MEM visit starts from zero
    assign wait_clear = (state_d != state_q);
    assign wait_count = in_wait_state && !Mem_Ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (wait_clear),
        .count   (wait_count),
        .expired (wait_expired)
    );

    // An instruction retires in WB, or in MEM for a store once memory accepts it
    assign retire = (state_q == ST_WB) ||
                    ((state_q == ST_MEM) && (class_q == CLS_SW) && Mem_Ready);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Mem_Ready in the expiring cycle takes priority over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (Mem_Ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (decode_class(Opcode) == CLS_NONE) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R, CLS_I:   state_d = ST_WB;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                if (Mem_Ready) begin
                    if (class_q == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = Enable ? ST_FETCH : ST_IDLE;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                state_d = Enable ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Class, trap cause and retire counter updates; the cause is only written on TRAP entry
    always_comb begin
        class_d = class_q;
        cause_d = cause_q;
        count_d = count_q;
        if (state_q == ST_DECODE) begin
            class_d = decode_class(Opcode);
        end
        if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
            cause_d = (state_q == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
        if (retire) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Class, trap cause and retire counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            class_q <= CLS_NONE;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
        end else begin
            class_q <= class_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Output decode from state and latched class; IR_Write and the store's PC_Write are
    // qualified by Mem_Ready so the IR loads valid data and the PC advances exactly once
    always_comb begin
        Mem_Req    = 1'b0;
        Mem_Sel    = 1'b0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        Reg_Write  = 1'b0;
        Mem_to_Reg = 1'b0;
        ALU_Src    = 1'b0;
        ALU_Op     = ALU_OP_IALU;
        case (state_q)
            ST_FETCH: begin
                Mem_Req  = 1'b1;
                IR_Write = Mem_Ready;
            end
            ST_EXEC: begin
                ALU_Op  = alu_op_of(class_q);
                ALU_Src = alu_src_of(class_q);
            end
            ST_MEM: begin
                Mem_Req   = 1'b1;
                Mem_Sel   = 1'b1;
                ALU_Op    = ALU_OP_ADD;
                ALU_Src   = 1'b1;
                Mem_Read  = (class_q == CLS_LW);
                Mem_Write = (class_q == CLS_SW);
                PC_Write  = (class_q == CLS_SW) && Mem_Ready;
            end
            ST_WB: begin
                Reg_Write  = 1'b1;
                Mem_to_Reg = (class_q == CLS_LW);
                ALU_Op     = alu_op_of(class_q);
                ALU_Src    = alu_src_of(class_q);
                PC_Write   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Busy        = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign Trap        = (state_q == ST_TRAP);
    assign Trap_Cause  = cause_q;
    assign Instr_Count = count_q;

endmodule
